// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store memory master.
// Optional build macro used by the top: LSU_PERF_CNT_EN.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_e;

    function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rep_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a memory word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_B:    data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SZ_H:    data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator for the core data memory port.
// Define LSU_PERF_CNT_EN to add load/store performance counter outputs.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 0,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_wr,
    input  logic [1:0]        io_req_size,
    input  logic              io_req_unsigned,
    input  logic [ADDR_W-1:0] io_req_addr,
    input  logic [31:0]       io_req_wdata,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [31:0]       io_resp_rdata,
    output logic              io_resp_err,
    output logic              io_mem_en,
    output logic              io_mem_wr,
    output logic [ADDR_W-1:0] io_mem_addr,
    output logic [31:0]       io_mem_wdata,
    output logic [3:0]        io_mem_wstrb,
    input  logic [31:0]       io_mem_rdata
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       io_ld_cnt,
    output logic [31:0]       io_st_cnt
`endif
);

    localparam int unsigned CNT_W  = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam int unsigned LAT_M1 = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       load_data;

    lsu_load_align u_load_align (
        .rdata       (io_mem_rdata),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_wstrb_d  = '0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (io_req_valid) begin
                    wr_d         = io_req_wr;
                    size_d       = io_req_size;
                    uns_d        = io_req_unsigned;
                    off_d        = io_req_addr[1:0];
                    resp_rdata_d = '0;
                    resp_err_d   = req_illegal(io_req_size, io_req_addr[1:0]);
                    if (resp_err_d) begin
                        state_d = RESP;
                    end else begin
                        // Memory outputs are registered, so the REQ-cycle values are set up here.
                        state_d    = REQ;
                        mem_en_d   = 1'b1;
                        mem_wr_d   = io_req_wr;
                        mem_addr_d = {io_req_addr[ADDR_W-1:2], 2'b00};
                        if (io_req_wr) begin
                            mem_wstrb_d = calc_wstrb(io_req_size, io_req_addr[1:0]);
                            mem_wdata_d = rep_wdata(io_req_size, io_req_wdata);
                        end
                    end
                end
            end
            REQ: begin
                if (wr_q) begin
                    state_d = RESP;
                end else if (RD_LATENCY == 0) begin
                    resp_rdata_d = load_data;
                    state_d      = RESP;
                end else begin
                    cnt_d   = CNT_W'(LAT_M1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    resp_rdata_d = load_data;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (io_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign io_req_ready  = (state_q == IDLE);
    assign io_resp_valid = (state_q == RESP);
    assign io_resp_rdata = resp_rdata_q;
    assign io_resp_err   = resp_err_q;
    assign io_mem_en     = mem_en_q;
    assign io_mem_wr     = mem_wr_q;
    assign io_mem_addr   = mem_addr_q;
    assign io_mem_wdata  = mem_wdata_q;
    assign io_mem_wstrb  = mem_wstrb_q;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] ld_cnt_q, ld_cnt_d;
    logic [31:0] st_cnt_q, st_cnt_d;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        if (state_q == REQ) begin
            if (wr_q) st_cnt_d = st_cnt_q + 32'd1;
            else      ld_cnt_d = ld_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign io_ld_cnt = ld_cnt_q;
    assign io_st_cnt = st_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench: two instances (RD_LATENCY 0 and 3) driven with identical requests.
module tb_lsu_mem_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memx_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        reset;
    logic        req_valid;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        mem_en     [2];
    logic        mem_wr     [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic [3:0]  mem_wstrb  [2];
    logic [31:0] mem_rdata  [2];
`ifdef LSU_PERF_CNT_EN
    logic [31:0] ld_cnt [2];
    logic [31:0] st_cnt [2];
`endif

    lsu_mem_master #(.RD_LATENCY(0), .ADDR_W(32)) u_lat0 (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid), .io_req_ready(req_ready[0]), .io_req_wr(req_wr),
        .io_req_size(req_size), .io_req_unsigned(req_uns), .io_req_addr(req_addr),
        .io_req_wdata(req_wdata), .io_resp_valid(resp_valid[0]), .io_resp_ready(resp_ready),
        .io_resp_rdata(resp_rdata[0]), .io_resp_err(resp_err[0]), .io_mem_en(mem_en[0]),
        .io_mem_wr(mem_wr[0]), .io_mem_addr(mem_addr[0]), .io_mem_wdata(mem_wdata[0]),
        .io_mem_wstrb(mem_wstrb[0]), .io_mem_rdata(mem_rdata[0])
`ifdef LSU_PERF_CNT_EN
        , .io_ld_cnt(ld_cnt[0]), .io_st_cnt(st_cnt[0])
`endif
    );

    lsu_mem_master #(.RD_LATENCY(3), .ADDR_W(32)) u_lat3 (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid), .io_req_ready(req_ready[1]), .io_req_wr(req_wr),
        .io_req_size(req_size), .io_req_unsigned(req_uns), .io_req_addr(req_addr),
        .io_req_wdata(req_wdata), .io_resp_valid(resp_valid[1]), .io_resp_ready(resp_ready),
        .io_resp_rdata(resp_rdata[1]), .io_resp_err(resp_err[1]), .io_mem_en(mem_en[1]),
        .io_mem_wr(mem_wr[1]), .io_mem_addr(mem_addr[1]), .io_mem_wdata(mem_wdata[1]),
        .io_mem_wstrb(mem_wstrb[1]), .io_mem_rdata(mem_rdata[1])
`ifdef LSU_PERF_CNT_EN
        , .io_ld_cnt(ld_cnt[1]), .io_st_cnt(st_cnt[1])
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Memory returns the real word only in the cycle each instance is expected to sample it.
    logic [31:0] rdv = 32'h0;
    int k3 = 0;
    always @(posedge clock) begin
        if (!reset)                k3 <= 0;
        else if (mem_en[1])        k3 <= 1;
        else if (k3 > 0 && k3 < 8) k3 <= k3 + 1;
        else                       k3 <= 0;
    end
    always_comb begin
        mem_rdata[0] = mem_en[0] ? rdv : ~rdv;
        mem_rdata[1] = (k3 == 3) ? rdv : ~rdv;
    end

    resp_t rq [2][$];
    memx_t mq [2][$];
    int nld = 0;
    int nst = 0;

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                string p;
                p = (i == 0) ? "L0" : "L3";
                if (mem_en[i]) begin
                    memx_t m;
                    check({p, "_mem_en_pending"}, 32'(mq[i].size()), 32'd1);
                    if (mq[i].size() > 0) begin
                        m = mq[i].pop_front();
                        check({p, "_mem_wr"},    32'(mem_wr[i]), 32'(m.wr));
                        check({p, "_mem_addr"},  mem_addr[i], m.addr);
                        check({p, "_mem_wstrb"}, 32'(mem_wstrb[i]), 32'(m.wstrb));
                        if (m.wr) check({p, "_mem_wdata"}, mem_wdata[i], m.wdata);
                    end
                end else begin
                    check({p, "_mem_idle"},
                          32'(|{mem_wr[i], mem_addr[i], mem_wdata[i], mem_wstrb[i]}), 32'd0);
                end
                if (resp_valid[i] && resp_ready) begin
                    resp_t r;
                    check({p, "_resp_pending"}, 32'(rq[i].size()), 32'd1);
                    if (rq[i].size() > 0) begin
                        r = rq[i].pop_front();
                        check({p, "_resp_rdata"}, resp_rdata[i], r.rdata);
                        check({p, "_resp_err"},   32'(resp_err[i]), 32'(r.err));
                    end
                end
            end
        end
    end

    function automatic void model(input logic wr, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rd, output resp_t r, output memx_t m,
                                  output logic err);
        logic [31:0] bl, hl;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        bl = rd >> (8 * addr[1:0]);
        hl = rd >> (16 * addr[1]);
        m.wr   = wr;
        m.addr = {addr[31:2], 2'b00};
        case (size)
            2'd0: begin
                m.wstrb = 4'b0001 << addr[1:0];
                m.wdata = {4{wdata[7:0]}};
                r.rdata = uns ? {24'h0, bl[7:0]} : {{24{bl[7]}}, bl[7:0]};
            end
            2'd1: begin
                m.wstrb = 4'b0011 << addr[1:0];
                m.wdata = {2{wdata[15:0]}};
                r.rdata = uns ? {16'h0, hl[15:0]} : {{16{hl[15]}}, hl[15:0]};
            end
            default: begin
                m.wstrb = 4'b1111;
                m.wdata = wdata;
                r.rdata = rd;
            end
        endcase
        if (!wr) m.wstrb = 4'b0000;
        if (wr || err) r.rdata = 32'h0;
        r.err = err;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!(req_ready[0] && req_ready[1]) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("req_ready_wait", {30'h0, req_ready[1], req_ready[0]}, 32'd3);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((rq[0].size() + rq[1].size()) != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("resp_drain", 32'(rq[0].size() + rq[1].size()), 32'd0);
    endtask

    int acc_cyc;

    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd);
        resp_t r;
        memx_t m;
        logic  err;
        wait_ready();
        rdv = rd;
        model(wr, size, uns, addr, wdata, rd, r, m, err);
        for (int i = 0; i < 2; i++) begin
            rq[i].push_back(r);
            if (!err) mq[i].push_back(m);
        end
        if (!err) begin
            if (wr) nst++;
            else    nld++;
        end
        req_wr    = wr;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clock);
        acc_cyc = cyc;
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom_range(0, 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, f1;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_size   = 2'd0;
        req_uns    = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            check("rst_resp_rdata", resp_rdata[i], 32'd0);
            check("rst_resp_err",   32'(resp_err[i]), 32'd0);
            check("rst_mem", 32'(|{mem_en[i], mem_wr[i], mem_addr[i], mem_wdata[i], mem_wstrb[i]}), 32'd0);
        end
        reset = 1'b1;
        @(negedge clock);
        check("rst_req_ready", {30'h0, req_ready[1], req_ready[0]}, 32'd3);

        // Store byte with timing of the zero-latency instance.
        do_req(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00AB, $urandom);
        @(negedge clock);
        check("st_mem_en_c1",   {30'h0, mem_en[1], mem_en[0]}, 32'd3);
        check("st_wstrb_c1",    32'(mem_wstrb[0]), 32'h8);
        check("st_wdata_c1",    mem_wdata[0], 32'hABAB_ABAB);
        @(negedge clock);
        check("st_resp_c2",     {30'h0, resp_valid[1], resp_valid[0]}, 32'd3);
        check("st_mem_en_c2",   32'(mem_en[0]), 32'd0);
        @(negedge clock);
        check("st_ready_c3",    32'(req_ready[0]), 32'd1);

        // Loads and stores across sizes and offsets.
        do_req(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_1234);
        do_req(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 32'h8001_1234);
        for (int o = 0; o < 4; o++) begin
            do_req(1'b0, 2'd0, 1'(o), 32'h8000_0100 + 32'(o), 32'h0, 32'h80F1_7F82);
        end
        do_req(1'b0, 2'd1, 1'b0, 32'h8000_0200, 32'h0, 32'h1234_F00D);
        do_req(1'b1, 2'd1, 1'b0, 32'h8000_0302, 32'hDEAD_BEEF, $urandom);
        do_req(1'b1, 2'd2, 1'b0, 32'h8000_0304, 32'hCAFE_F00D, $urandom);
        do_req(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0, 32'h7654_3210);

        // Error requests: misaligned word/half and illegal size.
        do_req(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, $urandom);
        do_req(1'b1, 2'd1, 1'b0, 32'h8000_0011, 32'h1234, $urandom);
        do_req(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, $urandom);
        wait_done();

        // Backpressure: response held while resp_ready is low; new requests ignored.
        resp_ready = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 32'h5A5A_C3C3);
        f0 = -1;
        f1 = -1;
        for (int n = 0; n < 20 && f1 < 0; n++) begin
            @(negedge clock);
            if (resp_valid[0] && f0 < 0) f0 = cyc;
            if (resp_valid[1] && f1 < 0) f1 = cyc;
        end
        check("lat0_resp_cycle", 32'(f0 - acc_cyc), 32'd2);
        check("lat3_resp_cycle", 32'(f1 - acc_cyc), 32'd5);
        req_wr    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h8000_0040;
        req_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                check("hold_valid", 32'(resp_valid[i]), 32'd1);
                check("hold_rdata", resp_rdata[i], 32'h5A5A_C3C3);
                check("hold_ready", 32'(req_ready[i]), 32'd0);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        wait_done();

        // Reset while the latency-3 instance is waiting on read data.
        do_req(1'b0, 2'd0, 1'b1, 32'h8000_0005, 32'h0, 32'h1122_8344);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_mem", 32'(|{mem_en[1], mem_wr[1], mem_addr[1], mem_wdata[1], mem_wstrb[1]}), 32'd0);
        check("abort_resp_valid", 32'(resp_valid[1]), 32'd0);
        rq[1].delete();
        mq[1].delete();
        nld = 0;
        nst = 0;
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", {30'h0, req_ready[1], req_ready[0]}, 32'd3);
        do_req(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 32'hA5A5_0F0F);

        // Mix for the counters: loads, stores and a misaligned request.
        do_req(1'b0, 2'd0, 1'b0, 32'h8000_0031, 32'h0, 32'h00FF_0000);
        do_req(1'b1, 2'd0, 1'b0, 32'h8000_0032, 32'h77, $urandom);
        do_req(1'b0, 2'd1, 1'b1, 32'h8000_0033, 32'h0, $urandom);
        do_req(1'b1, 2'd2, 1'b0, 32'h8000_0034, 32'h0BAD_CAFE, $urandom);
        do_req(1'b0, 2'd1, 1'b0, 32'h8000_0036, 32'h0, 32'hFFFE_0001);
        wait_done();
`ifdef LSU_PERF_CNT_EN
        for (int i = 0; i < 2; i++) begin
            check("ld_cnt", ld_cnt[i], 32'(nld));
            check("st_cnt", st_cnt[i], 32'(nst));
        end
`endif
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
